// File: rtl/cc_reg_file_pkg.sv
// cc_reg_file_pkg
// Purpose : shared constants for the condition-code register file:
//           register-map indices, the range of ALU opcodes that update
//           the PSR, and the bit positions of the flags inside the PSR.
// Ports   : none (package).
package cc_reg_file_pkg;

    // Register map. Index 0 is the hard-wired zero register and has no
    // storage. Indices at or above NUM_REGS are unmapped.
    localparam int R0_IDX    = 0;
    localparam int PC_IDX    = 32;
    localparam int TEMP0_IDX = 33;
    localparam int TEMP1_IDX = 34;
    localparam int TEMP2_IDX = 35;
    localparam int TEMP3_IDX = 36;
    localparam int IR_IDX    = 37;
    localparam int NUM_REGS  = 38;

    // Opcodes ANDCC, ORCC, NORCC and ADDCC form one contiguous block.
    localparam logic [3:0] CC_OP_FIRST = 4'b0000;
    localparam logic [3:0] CC_OP_LAST  = 4'b0011;

    // Flag positions inside the PSR: {N,Z,V,C}.
    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_V = 1;
    localparam int PSR_C = 0;

    // True when the opcode belongs to the condition-code group. The
    // subtraction folds both range bounds into one unsigned compare.
    function automatic logic is_cc_op(input logic [3:0] op);
        logic [3:0] offset;
        logic [3:0] span;
        offset = op - CC_OP_FIRST;
        span   = CC_OP_LAST - CC_OP_FIRST;
        return offset <= span;
    endfunction

endpackage

// File: rtl/cc_reg_file_psr.sv
// cc_psr
// Purpose : 4-bit processor status register holding {N,Z,V,C}.
//           Loads on the clock edge when load is high and holds otherwise;
//           the reset is synchronous and wins over a load.
// Ports   : clk   - clock, rising edge
//           rst   - synchronous active-high reset
//           load  - load enable
//           flags - next flag value, already packed as {N,Z,V,C}
//           psr   - registered flags
import cc_reg_file_pkg::*;

module cc_psr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] flags,
    output logic [3:0] psr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            psr <= '0;
        end else if (load) begin
            psr <= flags;
        end
    end

endmodule

// File: rtl/cc_reg_file.sv
// cc_reg_file
// Purpose : register file of r1-r31, PC, temp0-temp3 and IR, built from
//           flip-flops, with two combinational read ports and one
//           synchronous write port. Condition-code opcodes also latch the
//           ALU flags into the PSR on the write edge.
// Ports   : CC_REG_FILE_CLOCK_50          - clock, rising edge
//           CC_REG_FILE_RESET_InHigh      - synchronous active-high reset
//           CC_REG_FILE_DataBUSC_In       - write data
//           CC_REG_FILE_SelectionC_In     - write address
//           CC_REG_FILE_Write_InHigh      - write enable
//           CC_REG_FILE_SelectionA/B_In   - read addresses
//           CC_REG_FILE_DataBUSA/B_Out    - read data (zero latency)
//           CC_REG_FILE_ALUSelection_In   - ALU opcode of this cycle
//           CC_REG_FILE_Negative/Zero/Overflow/Carry_InHigh - ALU flags
//           CC_REG_FILE_PSR_Out           - latched {N,Z,V,C}
//           CC_REG_FILE_PC_Out/IR_Out     - direct views of PC and IR
import cc_reg_file_pkg::*;

module cc_reg_file #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_REG_SELECTION = 6
) (
    input  logic                               CC_REG_FILE_CLOCK_50,
    input  logic                               CC_REG_FILE_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]           CC_REG_FILE_DataBUSC_In,
    input  logic [DATAWIDTH_REG_SELECTION-1:0] CC_REG_FILE_SelectionC_In,
    input  logic                               CC_REG_FILE_Write_InHigh,
    input  logic [DATAWIDTH_REG_SELECTION-1:0] CC_REG_FILE_SelectionA_In,
    input  logic [DATAWIDTH_REG_SELECTION-1:0] CC_REG_FILE_SelectionB_In,
    output logic [DATAWIDTH_BUS-1:0]           CC_REG_FILE_DataBUSA_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_REG_FILE_DataBUSB_Out,
    input  logic [3:0]                         CC_REG_FILE_ALUSelection_In,
    input  logic                               CC_REG_FILE_Negative_InHigh,
    input  logic                               CC_REG_FILE_Zero_InHigh,
    input  logic                               CC_REG_FILE_Overflow_InHigh,
    input  logic                               CC_REG_FILE_Carry_InHigh,
    output logic [3:0]                         CC_REG_FILE_PSR_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_REG_FILE_PC_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_REG_FILE_IR_Out
);

    localparam int SEL_W = DATAWIDTH_REG_SELECTION;

    // r0 has no storage; only indices 1..NUM_REGS-1 are real flops.
    logic [DATAWIDTH_BUS-1:0] regs [1:NUM_REGS-1];

    logic [3:0] flags;
    logic       psr_load;

    // Write port. Each register compares the full select, so an unmapped
    // address matches nothing and cannot alias onto a mapped register.
    always_ff @(posedge CC_REG_FILE_CLOCK_50) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (CC_REG_FILE_RESET_InHigh) begin
                regs[i] <= '0;
            end else if (CC_REG_FILE_Write_InHigh &&
                         CC_REG_FILE_SelectionC_In == SEL_W'(i)) begin
                regs[i] <= CC_REG_FILE_DataBUSC_In;
            end
        end
    end

    // Read ports: plain muxes over the stored registers. Address 0 and
    // unmapped addresses fall through to the zero default. There is no
    // bypass from the write port, so a same-cycle write shows up only
    // after the edge.
    always_comb begin
        CC_REG_FILE_DataBUSA_Out = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (CC_REG_FILE_SelectionA_In == SEL_W'(i)) begin
                CC_REG_FILE_DataBUSA_Out = regs[i];
            end
        end
    end

    always_comb begin
        CC_REG_FILE_DataBUSB_Out = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (CC_REG_FILE_SelectionB_In == SEL_W'(i)) begin
                CC_REG_FILE_DataBUSB_Out = regs[i];
            end
        end
    end

    assign CC_REG_FILE_PC_Out = regs[PC_IDX];
    assign CC_REG_FILE_IR_Out = regs[IR_IDX];

    // Pack the flags using the shared bit positions.
    always_comb begin
        flags        = '0;
        flags[PSR_N] = CC_REG_FILE_Negative_InHigh;
        flags[PSR_Z] = CC_REG_FILE_Zero_InHigh;
        flags[PSR_V] = CC_REG_FILE_Overflow_InHigh;
        flags[PSR_C] = CC_REG_FILE_Carry_InHigh;
    end

    // The PSR load ignores the write address on purpose: a CC opcode that
    // targets r0 or an unmapped address acts as a compare.
    assign psr_load = CC_REG_FILE_Write_InHigh && is_cc_op(CC_REG_FILE_ALUSelection_In);

    cc_psr u_psr (
        .clk   (CC_REG_FILE_CLOCK_50),
        .rst   (CC_REG_FILE_RESET_InHigh),
        .load  (psr_load),
        .flags (flags),
        .psr   (CC_REG_FILE_PSR_Out)
    );

endmodule
